// File: rtl/wb_scratchpad_router.sv
// Wishbone router: requests that fall in the scratchpad window are served from local
// single-port memory; every other request is forwarded unchanged to the system bus.
module wb_scratchpad_router #(
  parameter logic [31:0] SCRATCH_BASE  = 32'h0000_0000,
  parameter int          SCRATCH_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_cyc_i,
  input  logic        core_stb_i,
  input  logic        core_we_i,
  input  logic [31:0] core_adr_i,
  input  logic [3:0]  core_sel_i,
  input  logic [31:0] core_dat_i,
  input  logic [2:0]  core_cti_i,
  input  logic [1:0]  core_bte_i,
  output logic        core_ack_o,
  output logic        core_err_o,
  output logic        core_rty_o,
  output logic [31:0] core_dat_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  output logic [2:0]  bus_cti_o,
  output logic [1:0]  bus_bte_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic        bus_rty_i,
  input  logic [31:0] bus_dat_i
);

  localparam int          IW         = $clog2(SCRATCH_WORDS);
  localparam logic [32:0] REGION_END = {1'b0, SCRATCH_BASE} + 33'(4 * SCRATCH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SP   = 2'd1,
    ST_BUS  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  state_t        w_state_eff;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic [IW-1:0] w_adr_idx;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [SCRATCH_WORDS];
  logic          w_req;
  logic          w_hit;
  logic          w_cti_ok;
  logic          w_sp_ack;
  logic          w_sp_err;
  logic          w_mem_we;
  logic          w_bypass;
  logic [31:0]   w_wr_word;

  function automatic logic [IW-1:0] burst_next(input logic [IW-1:0] idx, input logic [1:0] bte);
    logic [IW-1:0] n;
    n = idx;
    case (bte)
      2'b00:   n      = idx + IW'(1);
      2'b01:   n[1:0] = idx[1:0] + 2'd1;
      2'b10:   n[2:0] = idx[2:0] + 3'd1;
      default: n[3:0] = idx[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  // Reset forces the output view to IDLE so nothing is driven or written in the reset cycle.
  assign w_state_eff = rst_i ? r_state : ST_IDLE;
  assign w_req       = core_cyc_i & core_stb_i;
  assign w_hit       = ({1'b0, core_adr_i} >= {1'b0, SCRATCH_BASE}) && ({1'b0, core_adr_i} < REGION_END);
  assign w_adr_idx   = core_adr_i[IW+1:2];
  assign w_cti_ok    = (core_cti_i == 3'b000) || (core_cti_i == 3'b010) || (core_cti_i == 3'b111);
  assign w_sp_ack    = (w_state_eff == ST_SP) && w_req && w_cti_ok;
  assign w_sp_err    = (w_state_eff == ST_SP) && w_req && !w_cti_ok;
  assign w_mem_we    = w_sp_ack && core_we_i;
  assign w_wr_word   = merge_bytes(r_mem[r_idx], core_dat_i, core_sel_i);
  assign w_bypass    = w_mem_we && (w_idx_nxt == r_idx);

  // Next-state and burst index sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_req && w_hit) begin
          w_state_nxt = ST_SP;
          w_idx_nxt   = w_adr_idx;
        end else if (w_req) begin
          w_state_nxt = ST_BUS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SP: begin
        if (!core_cyc_i || w_sp_err) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sp_ack && (core_cti_i == 3'b010)) begin
          w_idx_nxt = burst_next(r_idx, core_bte_i);
        end else if (w_sp_ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SP;
        end
      end
      ST_BUS: begin
        if (!core_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUS;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Core and bus output steering.
  always_comb begin
    core_ack_o = 1'b0;
    core_err_o = 1'b0;
    core_rty_o = 1'b0;
    core_dat_o = 32'h0000_0000;
    bus_cyc_o  = 1'b0;
    bus_stb_o  = 1'b0;
    bus_we_o   = 1'b0;
    bus_adr_o  = 32'h0000_0000;
    bus_sel_o  = 4'b0000;
    bus_dat_o  = 32'h0000_0000;
    bus_cti_o  = 3'b000;
    bus_bte_o  = 2'b00;
    case (w_state_eff)
      ST_SP: begin
        core_ack_o = w_sp_ack;
        core_err_o = w_sp_err;
        core_dat_o = w_sp_ack ? r_rdata : 32'h0000_0000;
      end
      ST_BUS: begin
        bus_cyc_o  = core_cyc_i;
        bus_stb_o  = core_stb_i;
        bus_we_o   = core_we_i;
        bus_adr_o  = core_adr_i;
        bus_sel_o  = core_sel_i;
        bus_dat_o  = core_dat_i;
        bus_cti_o  = core_cti_i;
        bus_bte_o  = core_bte_i;
        // Ack wins over err so the core never sees both at once.
        core_ack_o = bus_ack_i & core_cyc_i;
        core_err_o = bus_err_i & core_cyc_i & ~bus_ack_i;
        core_rty_o = bus_rty_i & core_cyc_i;
        core_dat_o = bus_dat_i;
      end
      default: begin
        core_ack_o = 1'b0;
      end
    endcase
  end

  // State, latched word index and synchronous read port with write-first bypass.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rdata <= w_bypass ? w_wr_word : r_mem[w_idx_nxt];
    end
  end

  // Scratchpad storage; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= w_wr_word;
    end
  end

endmodule

// File: tb/tb_wb_scratchpad_router.sv
// Randomized bench for wb_scratchpad_router: a word-array model of the scratchpad and
// cycle-accurate expectations for the wait state, bursts, bus forwarding and reset abort.
module tb_wb_scratchpad_router;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WORDS = 64;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_cyc_i, core_stb_i, core_we_i;
  logic [31:0] core_adr_i, core_dat_i;
  logic [3:0]  core_sel_i;
  logic [2:0]  core_cti_i;
  logic [1:0]  core_bte_i;
  logic        core_ack_o, core_err_o, core_rty_o;
  logic [31:0] core_dat_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic [2:0]  bus_cti_o;
  logic [1:0]  bus_bte_o;
  logic        bus_ack_i, bus_err_i, bus_rty_i;
  logic [31:0] bus_dat_i;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] model_mem [WORDS];
  logic [31:0] rd;
  logic [2:0]  bad_cti [5] = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b110};

  always #5 clk_i = ~clk_i;

  wb_scratchpad_router #(.SCRATCH_BASE(BASE), .SCRATCH_WORDS(WORDS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_cyc_i(core_cyc_i), .core_stb_i(core_stb_i), .core_we_i(core_we_i),
    .core_adr_i(core_adr_i), .core_sel_i(core_sel_i), .core_dat_i(core_dat_i),
    .core_cti_i(core_cti_i), .core_bte_i(core_bte_i),
    .core_ack_o(core_ack_o), .core_err_o(core_err_o), .core_rty_o(core_rty_o),
    .core_dat_o(core_dat_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
    .bus_cti_o(bus_cti_o), .bus_bte_o(bus_bte_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rty_i(bus_rty_i),
    .bus_dat_i(bus_dat_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wrap block of 4/8/16 words for bte 1/2/3, whole region for bte 0.
  function automatic int next_idx(input int idx, input logic [1:0] bte);
    int s;
    if (bte == 2'b00) return (idx + 1) % WORDS;
    s = 2 << bte;
    return (idx / s) * s + (idx + 1) % s;
  endfunction

  function automatic logic [31:0] apply_sel(input logic [31:0] old_w, input logic [31:0] d,
                                            input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_w & ~mask) | (d & mask);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, 32'({core_ack_o, core_err_o, core_rty_o, bus_cyc_o, bus_stb_o,
                                 bus_we_o, bus_sel_o, bus_cti_o, bus_bte_o}), 32'd0);
    check_eq({tag, "_cdat"}, core_dat_o, 32'd0);
    check_eq({tag, "_badr"}, bus_adr_o, 32'd0);
    check_eq({tag, "_bdat"}, bus_dat_o, 32'd0);
  endtask

  task automatic drive_idle();
    core_cyc_i = 1'b0;
    core_stb_i = 1'b0;
    core_we_i  = 1'($urandom);
    core_adr_i = $urandom;
    core_dat_i = $urandom;
    core_sel_i = 4'($urandom);
    core_cti_i = 3'($urandom);
    core_bte_i = 2'($urandom);
  endtask

  task automatic idle_cycle();
    drive_idle();
    @(negedge clk_i);
    check_zero("idle");
    step();
  endtask

  // Scratchpad transfer of n beats; rst_beat >= 1 pulls reset low during that beat.
  task automatic sp_xfer(input logic we, input int idx0, input logic [1:0] bte, input int n,
                         input int rst_beat, input logic rand_sel, input logic [3:0] sel0,
                         input logic [31:0] dat0, output logic [31:0] last_rd);
    int idx = idx0;
    last_rd    = 32'd0;
    core_cyc_i = 1'b1;
    core_stb_i = 1'b1;
    core_we_i  = we;
    core_adr_i = BASE + 32'(4 * idx);
    core_sel_i = sel0;
    core_dat_i = dat0;
    core_cti_i = (n == 1) ? 3'b000 : 3'b010;
    core_bte_i = bte;
    @(negedge clk_i);
    check_eq("sp_wait", 32'({core_ack_o, core_err_o, core_rty_o, bus_cyc_o}), 32'd0);
    step();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        core_adr_i = BASE + 32'(4 * idx);
        core_sel_i = rand_sel ? 4'($urandom) : 4'hF;
        core_dat_i = $urandom;
        core_cti_i = (k == n - 1) ? 3'b111 : 3'b010;
      end
      if (k == rst_beat) begin
        rst_i = 1'b0;
        @(negedge clk_i);
        check_zero("rst_mid");
        step();
        rst_i      = 1'b1;
        core_cyc_i = 1'b0;
        core_stb_i = 1'b0;
        return;
      end
      @(negedge clk_i);
      check_eq("sp_beat", 32'({core_ack_o, core_err_o, core_rty_o, bus_cyc_o, bus_stb_o}), 32'h10);
      if (!we) begin
        check_eq("sp_rdata", core_dat_o, model_mem[idx]);
        last_rd = core_dat_o;
      end else begin
        model_mem[idx] = apply_sel(model_mem[idx], core_dat_i, core_sel_i);
      end
      step();
      idx = next_idx(idx, bte);
    end
    core_cyc_i = 1'b0;
    core_stb_i = 1'b0;
  endtask

  task automatic err_xfer(input int idx, input logic we, input logic [2:0] cti);
    core_cyc_i = 1'b1;
    core_stb_i = 1'b1;
    core_we_i  = we;
    core_adr_i = BASE + 32'(4 * idx);
    core_sel_i = 4'hF;
    core_dat_i = $urandom;
    core_cti_i = cti;
    core_bte_i = 2'($urandom);
    @(negedge clk_i);
    check_eq("err_wait", 32'({core_ack_o, core_err_o}), 32'd0);
    step();
    @(negedge clk_i);
    check_eq("sp_err", 32'({core_ack_o, core_err_o, core_rty_o, bus_cyc_o}), 32'h4);
    step();
    core_cyc_i = 1'b0;
    core_stb_i = 1'b0;
  endtask

  // resp: 0 ack, 1 err, 2 rty.
  task automatic bus_xfer(input logic [31:0] adr, input logic we, input int resp, input int waits,
                          input logic [31:0] rdat);
    logic [2:0] resp_v;
    resp_v     = (resp == 0) ? 3'b100 : (resp == 1) ? 3'b010 : 3'b001;
    core_cyc_i = 1'b1;
    core_stb_i = 1'b1;
    core_we_i  = we;
    core_adr_i = adr;
    core_sel_i = 4'($urandom);
    core_dat_i = $urandom;
    core_cti_i = 3'($urandom);
    core_bte_i = 2'($urandom);
    @(negedge clk_i);
    check_eq("bus_req", 32'({bus_cyc_o, bus_stb_o, core_ack_o, core_err_o}), 32'd0);
    step();
    for (int w = 0; w <= waits; w++) begin
      if (w == waits) begin
        bus_ack_i = resp_v[2];
        bus_err_i = resp_v[1];
        bus_rty_i = resp_v[0];
        bus_dat_i = rdat;
      end else begin
        bus_dat_i = $urandom;
      end
      @(negedge clk_i);
      check_eq("bus_adr", bus_adr_o, adr);
      check_eq("bus_wdat", bus_dat_o, core_dat_i);
      check_eq("bus_ctl", 32'({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_cti_o, bus_bte_o}),
               32'({2'b11, we, core_sel_i, core_cti_i, core_bte_i}));
      check_eq("bus_resp", 32'({core_ack_o, core_err_o, core_rty_o}),
               (w == waits) ? 32'(resp_v) : 32'd0);
      if (w == waits) check_eq("bus_rdat", core_dat_o, rdat);
      step();
    end
    core_cyc_i = 1'b0;
    core_stb_i = 1'b0;
    bus_ack_i  = 1'b1;
    bus_err_i  = 1'b0;
    bus_rty_i  = 1'b0;
    @(negedge clk_i);
    check_eq("bus_late_ack", 32'({core_ack_o, core_err_o, core_rty_o, bus_cyc_o}), 32'd0);
    step();
    bus_ack_i = 1'b0;
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] adr;
    rst_i      = 1'b0;
    bus_ack_i  = 1'b0;
    bus_err_i  = 1'b0;
    bus_rty_i  = 1'b0;
    bus_dat_i  = 32'hDEAD_BEEF;
    core_cyc_i = 1'b1;
    core_stb_i = 1'b1;
    core_we_i  = 1'b1;
    core_adr_i = 32'h0000_0010;
    core_sel_i = 4'hF;
    core_dat_i = 32'h1234_5678;
    core_cti_i = 3'b000;
    core_bte_i = 2'b00;
    @(posedge clk_i);
    #1;
    repeat (3) begin
      @(negedge clk_i);
      check_zero("reset");
      step();
    end
    rst_i = 1'b1;

    // Fill the whole scratchpad, starting in the first cycle out of reset.
    sp_xfer(1'b1, 0, 2'b00, WORDS, -1, 1'b0, 4'hF, $urandom, rd);

    sp_xfer(1'b1, 4, 2'b00, 1, -1, 1'b0, 4'hF, 32'h0, rd);
    sp_xfer(1'b1, 4, 2'b00, 1, -1, 1'b0, 4'b0011, 32'hAABB_CCDD, rd);
    sp_xfer(1'b0, 4, 2'b00, 1, -1, 1'b0, 4'hF, 32'h0, rd);
    check_eq("classic_rd", rd, 32'h0000_CCDD);

    sp_xfer(1'b0, 14, 2'b01, 4, -1, 1'b0, 4'hF, 32'h0, rd);
    check_eq("wrap4_last", rd, model_mem[13]);

    sp_xfer(1'b1, 63, 2'b00, 3, -1, 1'b1, 4'hF, 32'h5A5A_0F0F, rd);
    sp_xfer(1'b0, 63, 2'b00, 3, -1, 1'b0, 4'hF, 32'h0, rd);

    bus_xfer(32'h0000_1000, 1'b0, 0, 0, 32'h1234_5678);
    bus_xfer(32'h0000_1000, 1'b1, 1, 2, 32'h0BAD_0BAD);
    bus_xfer(32'h8000_0004, 1'b0, 2, 1, 32'h0);

    err_xfer(8, 1'b1, 3'b011);
    sp_xfer(1'b0, 8, 2'b00, 1, -1, 1'b0, 4'hF, 32'h0, rd);

    sp_xfer(1'b1, 20, 2'b00, 4, 1, 1'b0, 4'hF, $urandom, rd);
    sp_xfer(1'b0, 20, 2'b00, 4, -1, 1'b0, 4'hF, 32'h0, rd);
    idle_cycle();

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          sp_xfer(1'($urandom), int'($urandom_range(0, WORDS - 1)), 2'($urandom),
                  int'($urandom_range(1, 8)), -1, 1'b1, 4'($urandom), $urandom, rd);
        6:
          err_xfer(int'($urandom_range(0, WORDS - 1)), 1'($urandom), bad_cti[$urandom_range(0, 4)]);
        7, 8: begin
          adr = $urandom;
          if (adr < BASE + 32'(4 * WORDS)) adr = adr + 32'h0000_1000;
          bus_xfer(adr, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom);
        end
        default: idle_cycle();
      endcase
    end

    // Read back everything so stray writes anywhere are caught.
    sp_xfer(1'b0, 0, 2'b00, WORDS, -1, 1'b0, 4'hF, 32'h0, rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_scratchpad_router.md
WB_SCRATCHPAD_ROUTER -- requirements
Module: wb_scratchpad_router

Interface
REQ-001 SHALL have parameter SCRATCH_BASE, default 32'h0000_0000: byte base address of scratchpad region, aligned to region size.
REQ-002 SHALL have parameter SCRATCH_WORDS, default 64: scratchpad depth in 32-bit words; power of two, >=16.
REQ-003 SHALL have port clk_i  in  1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1: reset, synchronous and active-low.
REQ-005 SHALL have core-side WB slave inputs: core_cyc_i 1, core_stb_i 1, core_we_i 1, core_adr_i 32, core_sel_i 4, core_dat_i 32, core_cti_i 3, core_bte_i 2.
REQ-006 SHALL have core-side WB slave outputs: core_ack_o 1, core_err_o 1, core_rty_o 1, core_dat_o 32.
REQ-007 SHALL have bus-side WB master outputs: bus_cyc_o 1, bus_stb_o 1, bus_we_o 1, bus_adr_o 32, bus_sel_o 4, bus_dat_o 32, bus_cti_o 3, bus_bte_o 2.
REQ-008 SHALL have bus-side WB master inputs: bus_ack_i 1, bus_err_i 1, bus_rty_i 1, bus_dat_i 32.

Function
REQ-009 Hit SHALL be SCRATCH_BASE <= core_adr_i < SCRATCH_BASE + 4*SCRATCH_WORDS; word index = core_adr_i[log2(SCRATCH_WORDS)+1:2].
REQ-010 FSM states SHALL be IDLE, SP, BUS; only IDLE decodes hit/miss.
REQ-011 IDLE: core_cyc_i & core_stb_i & hit -> SP, index latched, synchronous memory read issued; & !hit -> BUS; no ack/err/rty driven in IDLE.
REQ-012 SP: core_ack_o SHALL be 1 each cycle core_cyc_i & core_stb_i are high; first beat acks exactly one cycle after the IDLE request (one wait state).
REQ-013 SP write beat SHALL update only bytes whose core_sel_i bit is 1, in the ack cycle.
REQ-014 SP read beat SHALL return mem[index] on core_dat_o; a read of a word written in the preceding beat SHALL return the new data (write-first bypass).
REQ-015 SP burst: core_cti_i=3'b010 on an acked beat SHALL advance index next cycle and ack every cycle (zero wait) thereafter.
REQ-016 Burst advance: bte 00 linear +1; bte 01/10/11 wrap within 4/8/16-word aligned block; index arithmetic modulo SCRATCH_WORDS (region wrap, no escape to bus).
REQ-017 SP SHALL return to IDLE after an acked beat with core_cti_i in {000,111}, or when core_cyc_i is low.
REQ-018 SP request with core_cti_i in {001,011,100,101,110} SHALL get core_err_o=1 for one cycle, no memory write, then IDLE.
REQ-019 BUS: bus_* SHALL equal core_* combinationally (bus_cyc_o=core_cyc_i, bus_stb_o=core_stb_i, etc.); core_ack_o/err_o/rty_o/dat_o SHALL equal bus_ack_i/err_i/rty_i/dat_i.
REQ-020 BUS SHALL return to IDLE the cycle after core_cyc_i is sampled low; a bus_ack_i arriving with core_cyc_i low SHALL not be forwarded.
REQ-021 Outside BUS, bus_cyc_o and bus_stb_o SHALL be 0; bus_adr_o/dat_o/sel_o/cti_o/bte_o/we_o SHALL be 0.
REQ-022 core_rty_o SHALL be 0 outside BUS; core_ack_o, core_err_o never simultaneously 1.

Reset
REQ-023 While rst_i=0: state IDLE, all core_* and bus_* outputs 0, latched index 0; memory contents not reset.
REQ-024 Reset asserted mid-SP or mid-BUS SHALL abort: no ack on the following cycle, no memory write in the reset cycle.
REQ-025 First request is accepted in the first cycle after rst_i returns to 1.

Verification
REQ-026 Classic write adr 0x10, sel 4'b0011, dat 0xAABBCCDD over mem 0x0; then read 0x10 -> ack at cycle+1 each, data 0x0000CCDD.
REQ-027 Read burst adr 0x38, cti 010, bte 01, 4 beats (last cti 111) -> words 14,15,12,13, ack on 4 consecutive cycles after one wait.
REQ-028 Linear write burst from last word (index 63) -> second beat writes index 0; bus_cyc_o stays 0 throughout.
REQ-029 Read adr 0x1000 (miss) -> bus_cyc_o rises one cycle after request, bus_dat_i 0x12345678 with bus_ack_i -> core_ack_o, core_dat_o=0x12345678 same cycle; bus_err_i -> core_err_o.
REQ-030 Scratchpad request with cti 011 -> core_err_o one cycle, memory unchanged, next IDLE request serviced normally.
REQ-031 rst_i=0 during second beat of 4-beat write burst -> no ack next cycle, beats 2-4 not written, all outputs 0, fresh request after reset acks normally.
